// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment scan driver with frame-synchronous shadow.
// Optional blink feature enabled by defining SEVSEG_BLINK_EN.
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int DEADTIME       = 8,
    parameter int LZ_BLANK       = 1,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
`ifdef SEVSEG_BLINK_EN
    ,
    parameter int BLINK_FRAMES   = 64
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
`ifdef SEVSEG_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_in,
`endif
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_done
);

    localparam int   DIV_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int   IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic SEG_POL = (SEG_ACTIVE_LOW != 0);
    localparam logic AN_POL  = (AN_ACTIVE_LOW != 0);

    logic [DIV_W-1:0]          r_div_cnt;
    logic [IDX_W-1:0]          r_digit_idx;
    logic [4*NUM_DIGITS-1:0]   r_act_val;
    logic [NUM_DIGITS-1:0]     r_act_dp;
    logic [4*NUM_DIGITS-1:0]   r_pend_val;
    logic [NUM_DIGITS-1:0]     r_pend_dp;
    logic                      r_pend_vld;
    logic [6:0]                r_seg;
    logic                      r_dp;
    logic [NUM_DIGITS-1:0]     r_an;
    logic                      r_frame_done;

    logic                      w_slot_end;
    logic                      w_last_digit;
    logic                      w_frame_end;
    logic                      w_dead;
    logic [3:0]                w_nibble;
    logic [NUM_DIGITS-1:0]     w_blank;
    logic                      w_hz;
    logic [NUM_DIGITS-1:0]     w_dark;
    logic [NUM_DIGITS-1:0]     w_an_pre;
    logic [6:0]                w_seg_pre;
    logic                      w_dp_pre;

    function automatic logic [6:0] f_decode(input logic [3:0] n);
        case (n)
            4'h0:    f_decode = 7'h7E;
            4'h1:    f_decode = 7'h30;
            4'h2:    f_decode = 7'h6D;
            4'h3:    f_decode = 7'h79;
            4'h4:    f_decode = 7'h33;
            4'h5:    f_decode = 7'h5B;
            4'h6:    f_decode = 7'h5F;
            4'h7:    f_decode = 7'h70;
            4'h8:    f_decode = 7'h7F;
            4'h9:    f_decode = 7'h7B;
            4'hA:    f_decode = 7'h77;
            4'hB:    f_decode = 7'h1F;
            4'hC:    f_decode = 7'h4E;
            4'hD:    f_decode = 7'h3D;
            4'hE:    f_decode = 7'h4F;
            default: f_decode = 7'h47;
        endcase
    endfunction

    assign w_slot_end   = (r_div_cnt == DIV_W'(REFRESH_DIV - 1));
    assign w_last_digit = (r_digit_idx == IDX_W'(NUM_DIGITS - 1));
    assign w_frame_end  = w_slot_end && w_last_digit;
    assign w_dead       = (r_div_cnt < DIV_W'(DEADTIME));
    assign w_nibble     = r_act_val[{r_digit_idx, 2'b00} +: 4];

    // A digit is a leading zero when it and every higher nibble are zero
    always_comb begin
        w_blank = '0;
        w_hz    = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_hz = w_hz & (r_act_val[i*4 +: 4] == 4'h0);
            if (i > 0 && LZ_BLANK != 0) begin
                w_blank[i] = w_hz;
            end
        end
    end

`ifdef SEVSEG_BLINK_EN
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    logic [BLK_W-1:0] r_blink_cnt;
    logic             r_blink_phase;

    // Blink phase flips every BLINK_FRAMES frame boundaries, starting visible
    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
        end else if (w_frame_end) begin
            if (r_blink_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    assign w_dark = r_blink_phase ? '0 : blink_in;
`else
    assign w_dark = '0;
`endif

    // Pre-polarity pin values for the digit currently in its slot
    always_comb begin
        w_an_pre  = w_dead ? '0 : (NUM_DIGITS'(1) << r_digit_idx);
        w_seg_pre = f_decode(w_nibble);
        w_dp_pre  = r_act_dp[r_digit_idx];
        if (w_blank[r_digit_idx] || w_dark[r_digit_idx]) begin
            w_seg_pre = 7'h00;
        end
        if (w_dark[r_digit_idx]) begin
            w_dp_pre = 1'b0;
        end
    end

    // Divider, digit scan, pending capture and frame-boundary handover
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt   <= '0;
            r_digit_idx <= '0;
            r_act_val   <= '0;
            r_act_dp    <= '0;
            r_pend_val  <= '0;
            r_pend_dp   <= '0;
            r_pend_vld  <= 1'b0;
        end else begin
            if (w_slot_end) begin
                r_div_cnt   <= '0;
                r_digit_idx <= w_last_digit ? '0 : r_digit_idx + 1'b1;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
            if (w_frame_end && load) begin
                r_act_val  <= value_in;
                r_act_dp   <= dp_in;
                r_pend_vld <= 1'b0;
            end else if (w_frame_end && r_pend_vld) begin
                r_act_val  <= r_pend_val;
                r_act_dp   <= r_pend_dp;
                r_pend_vld <= 1'b0;
            end else if (load) begin
                r_pend_val <= value_in;
                r_pend_dp  <= dp_in;
                r_pend_vld <= 1'b1;
            end
        end
    end

    // Registered pins, polarity applied last
    always_ff @(posedge clk) begin
        if (rst) begin
            r_an         <= {NUM_DIGITS{AN_POL}};
            r_seg        <= {7{SEG_POL}};
            r_dp         <= SEG_POL;
            r_frame_done <= 1'b0;
        end else begin
            r_an         <= w_an_pre ^ {NUM_DIGITS{AN_POL}};
            r_seg        <= w_seg_pre ^ {7{SEG_POL}};
            r_dp         <= w_dp_pre ^ SEG_POL;
            r_frame_done <= w_frame_end;
        end
    end

    assign an_out     = r_an;
    assign seg_out    = r_seg;
    assign dp_out     = r_dp;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed self-checking bench for seven_seg_scan_driver (4 digits, 4-cycle slots).
// Blink scenario is compiled only when SEVSEG_BLINK_EN is defined.
module tb_seven_seg_scan_driver;

    logic        clk;
    logic        rst;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic        load;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [3:0]  an_out;
    logic        frame_done;
`ifdef SEVSEG_BLINK_EN
    logic [3:0]  blink_in;
`endif

    int checks;
    int errors;

    logic [6:0] seg_cap [4];
    logic       dp_cap  [4];
    logic [3:0] an_cap  [4];
    logic [3:0] gap_an  [4];

    seven_seg_scan_driver #(
        .NUM_DIGITS    (4),
        .REFRESH_DIV   (4),
        .DEADTIME      (1),
        .LZ_BLANK      (1),
        .SEG_ACTIVE_LOW(0),
        .AN_ACTIVE_LOW (0)
`ifdef SEVSEG_BLINK_EN
        ,
        .BLINK_FRAMES  (2)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .value_in  (value_in),
        .dp_in     (dp_in),
        .load      (load),
`ifdef SEVSEG_BLINK_EN
        .blink_in  (blink_in),
`endif
        .seg_out   (seg_out),
        .dp_out    (dp_out),
        .an_out    (an_out),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_fd();
        int n;
        n = 0;
        while (!frame_done && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL wait_fd: frame_done=%b after %0d cycles, required 1", frame_done, n);
        end
    endtask

    // Records one full frame; optional load pulses sampled at edge j of the frame
    task automatic capture_frame(input int la1, input logic [15:0] v1, input logic [3:0] p1,
                                 input int la2, input logic [15:0] v2, input logic [3:0] p2);
        wait_fd();
        for (int j = 1; j <= 16; j++) begin
            if (j == la1) begin
                value_in = v1; dp_in = p1; load = 1'b1;
            end else if (j == la2) begin
                value_in = v2; dp_in = p2; load = 1'b1;
            end
            @(negedge clk);
            load = 1'b0;
            if (j % 4 == 1) gap_an[(j-1)/4] = an_out;
            if (j % 4 == 3) begin
                seg_cap[(j-1)/4] = seg_out;
                dp_cap[(j-1)/4]  = dp_out;
                an_cap[(j-1)/4]  = an_out;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (an_out !== 4'b0000 || seg_out !== 7'h00 || dp_out !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: an=%b seg=%h dp=%b fd=%b, required 0000/00/0/0",
                     an_out, seg_out, dp_out, frame_done);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (an_out !== 4'b0000) begin
            errors++;
            $display("FAIL reset_dead: an=%b, required 0000", an_out);
        end
        @(negedge clk);
        checks++;
        if (an_out !== 4'b0001 || seg_out !== 7'h7E) begin
            errors++;
            $display("FAIL reset_first: an=%b seg=%h, required 0001/7e", an_out, seg_out);
        end
    endtask

    task automatic test_load_midframe();
        logic [27:0] e;
        capture_frame(5, 16'h12AF, 4'b0000, -1, 16'h0, 4'b0);
        e = {7'h00, 7'h00, 7'h00, 7'h7E};
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (seg_cap[d] !== e[d*7 +: 7]) begin
                errors++;
                $display("FAIL load_old_frame d%0d: seg=%h, required %h", d, seg_cap[d], e[d*7 +: 7]);
            end
        end
        capture_frame(-1, 16'h0, 4'b0, -1, 16'h0, 4'b0);
        e = {7'h30, 7'h6D, 7'h77, 7'h47};
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (seg_cap[d] !== e[d*7 +: 7]) begin
                errors++;
                $display("FAIL load_new_frame d%0d: seg=%h, required %h", d, seg_cap[d], e[d*7 +: 7]);
            end
            checks++;
            if (an_cap[d] !== (4'b0001 << d)) begin
                errors++;
                $display("FAIL anode_onehot d%0d: an=%b, required %b", d, an_cap[d], 4'b0001 << d);
            end
            checks++;
            if (gap_an[d] !== 4'b0000) begin
                errors++;
                $display("FAIL anode_gap d%0d: an=%b, required 0000", d, gap_an[d]);
            end
        end
    endtask

    task automatic test_lz_blank();
        logic [27:0] e;
        logic [3:0]  p;
        capture_frame(5, 16'h0030, 4'b1000, -1, 16'h0, 4'b0);
        capture_frame(-1, 16'h0, 4'b0, -1, 16'h0, 4'b0);
        e = {7'h00, 7'h00, 7'h79, 7'h7E};
        p = 4'b1000;
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (seg_cap[d] !== e[d*7 +: 7] || dp_cap[d] !== p[d]) begin
                errors++;
                $display("FAIL lz_blank d%0d: seg=%h dp=%b, required %h/%b",
                         d, seg_cap[d], dp_cap[d], e[d*7 +: 7], p[d]);
            end
        end
    endtask

    task automatic test_boundary_load();
        logic [27:0] e;
        capture_frame(16, 16'h8888, 4'b0000, -1, 16'h0, 4'b0);
        e = {7'h00, 7'h00, 7'h79, 7'h7E};
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (seg_cap[d] !== e[d*7 +: 7]) begin
                errors++;
                $display("FAIL boundary_old d%0d: seg=%h, required %h", d, seg_cap[d], e[d*7 +: 7]);
            end
        end
        capture_frame(-1, 16'h0, 4'b0, -1, 16'h0, 4'b0);
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (seg_cap[d] !== 7'h7F || dp_cap[d] !== 1'b0) begin
                errors++;
                $display("FAIL boundary_new d%0d: seg=%h dp=%b, required 7f/0", d, seg_cap[d], dp_cap[d]);
            end
        end
    endtask

    task automatic test_double_load();
        capture_frame(3, 16'h1111, 4'b0000, 9, 16'h2222, 4'b0000);
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (seg_cap[d] !== 7'h7F) begin
                errors++;
                $display("FAIL double_old d%0d: seg=%h, required 7f", d, seg_cap[d]);
            end
        end
        capture_frame(-1, 16'h0, 4'b0, -1, 16'h0, 4'b0);
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (seg_cap[d] !== 7'h6D) begin
                errors++;
                $display("FAIL double_last d%0d: seg=%h, required 6d", d, seg_cap[d]);
            end
        end
    endtask

    task automatic test_frame_done();
        int n;
        wait_fd();
        @(negedge clk);
        n = 1;
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL fd_width: frame_done=%b one cycle after pulse, required 0", frame_done);
        end
        while (!frame_done && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL fd_period: period=%0d cycles, required 16", n);
        end
    endtask

    task automatic test_mid_reset();
        wait_fd();
        repeat (2) @(negedge clk);
        value_in = 16'h5555; dp_in = 4'b1111; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (an_out !== 4'b0000 || seg_out !== 7'h00 || dp_out !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_out: an=%b seg=%h dp=%b fd=%b, required 0000/00/0/0",
                     an_out, seg_out, dp_out, frame_done);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (an_out !== 4'b0001 || seg_out !== 7'h7E) begin
            errors++;
            $display("FAIL midreset_restart: an=%b seg=%h, required 0001/7e", an_out, seg_out);
        end
        capture_frame(-1, 16'h0, 4'b0, -1, 16'h0, 4'b0);
        checks++;
        if (seg_cap[0] !== 7'h7E || seg_cap[1] !== 7'h00 || dp_cap[0] !== 1'b0) begin
            errors++;
            $display("FAIL midreset_pending: seg0=%h seg1=%h dp0=%b, required 7e/00/0",
                     seg_cap[0], seg_cap[1], dp_cap[0]);
        end
    endtask

`ifdef SEVSEG_BLINK_EN
    task automatic test_blink();
        logic [4:0] lit;
        lit = 5'b11001;
        blink_in = 4'b0001;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        value_in = 16'h1234; dp_in = 4'b0001; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int f = 0; f < 5; f++) begin
            capture_frame(-1, 16'h0, 4'b0, -1, 16'h0, 4'b0);
            checks++;
            if (seg_cap[0] !== (lit[f] ? 7'h33 : 7'h00) || dp_cap[0] !== lit[f]) begin
                errors++;
                $display("FAIL blink_d0 frame%0d: seg=%h dp=%b, required %h/%b",
                         f + 2, seg_cap[0], dp_cap[0], lit[f] ? 7'h33 : 7'h00, lit[f]);
            end
            checks++;
            if (seg_cap[1] !== 7'h79 || an_cap[0] !== 4'b0001) begin
                errors++;
                $display("FAIL blink_other frame%0d: seg1=%h an0=%b, required 79/0001",
                         f + 2, seg_cap[1], an_cap[0]);
            end
        end
    endtask
`endif

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        value_in = 16'h0;
        dp_in    = 4'b0;
        load     = 1'b0;
`ifdef SEVSEG_BLINK_EN
        blink_in = 4'b0;
`endif
        test_reset();
        test_load_midframe();
        test_lz_blank();
        test_boundary_load();
        test_double_load();
        test_frame_done();
        test_mid_reset();
`ifdef SEVSEG_BLINK_EN
        test_blink();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
